// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 16x8 RAM between two requesters.
// Round-robin arbitration with a 3-state access sequencer (IDLE/ACCESS/RESP).
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins on contention.
module ram_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [DEPTH-1:0] addr0,
  input  logic [DEPTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_wr_en,
  output logic             ram_rd_en,
  input  logic [WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [DEPTH-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_din_q, ram_din_d;
  logic             ram_wr_en_q, ram_wr_en_d, ram_rd_en_q, ram_rd_en_d;
  logic             win_c;
`ifndef ARB_FIXED_PRIO_EN
  logic             rr_q, rr_d;
`endif

  // Winner selection when at least one request is pending
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win_c = ~req0;
`else
    win_c = (req0 & req1) ? rr_q : req1;
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wr_en_d = 1'b0;
    ram_rd_en_d = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          id_d    = win_c;
          we_d    = win_c ? we1 : we0;
          addr_d  = win_c ? addr1 : addr0;
          wdata_d = win_c ? wdata1 : wdata0;
          gnt0_d  = ~win_c;
          gnt1_d  = win_c;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = ~win_c;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        ram_addr_d  = addr_q;
        ram_din_d   = wdata_q;
        ram_wr_en_d = we_q;
        ram_rd_en_d = ~we_q;
        state_d     = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (id_q) begin
          rdata1_d  = ram_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_dout;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wr_en_q <= 1'b0;
      ram_rd_en_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_wr_en_q <= ram_wr_en_d;
      ram_rd_en_q <= ram_rd_en_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_wr_en = ram_wr_en_q;
  assign ram_rd_en = ram_rd_en_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: RAM model, read-data scoreboard, directed and random steps.
module tb_ram_arbiter;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         req0, req1, we0, we1;
  logic [D-1:0] addr0, addr1;
  logic [W-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata0, rdata1;
  logic [D-1:0] ram_addr;
  logic [W-1:0] ram_din;
  logic         ram_wr_en, ram_rd_en;
  logic [W-1:0] ram_dout;

  ram_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_dout(ram_dout)
  );

  // RAM model: synchronous write, read data presented while the read strobe is up
  logic [W-1:0] mem [16];
  logic         mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = ram_rd_en ? mem[ram_addr] : '0;

  int           tests;
  int           fails;
  logic [W-1:0] mdl [16];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic         hold0, hold1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic id, input logic we, input logic [D-1:0] a, input logic [W-1:0] d);
    if (we) mdl[a] = d;
    else if (id) q1.push_back(mdl[a]);
    else q0.push_back(mdl[a]);
  endtask

  // One clock: sample after the edge, track grants, score read data
  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
    chk("strobe_excl", 64'(ram_wr_en & ram_rd_en), 64'd0);
    chk("rvalid_excl", 64'(rvalid0 & rvalid1), 64'd0);
    if (gnt0) begin
      apply(1'b0, we0, addr0, wdata0);
      if (!hold0) req0 = 1'b0;
    end
    if (gnt1) begin
      apply(1'b1, we1, addr1, wdata1);
      if (!hold1) req1 = 1'b0;
    end
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 64'(rvalid0), 64'd0);
      else chk("rdata0_sb", 64'(rdata0), 64'(q0.pop_front()));
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 64'(rvalid1), 64'd0);
      else chk("rdata1_sb", 64'(rdata1), 64'(q1.pop_front()));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                  ram_addr, ram_din, ram_wr_en, ram_rd_en}), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    q0.delete();
    q1.delete();
    chk_zero("reset_outputs");
    rstn = 1'b1;
  endtask

  // Issue one command and let it complete
  task automatic run_cmd(input logic id, input logic we, input logic [D-1:0] a, input logic [W-1:0] d);
    logic got;
    got = 1'b0;
    if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = id ? gnt1 : gnt0;
    end
    chk("gnt_timeout", 64'(got), 64'd1);
    if (!got) begin req0 = 1'b0; req1 = 1'b0; end
    tick();
    tick();
    tick();
  endtask

  int seq [4];
  int ng, nr;
  int gcyc [2];
  int rcyc [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    hold0 = 1'b0; hold1 = 1'b0; mem_clr = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    // Reset held for two clocks
    tick();
    mem_clr = 1'b0;
    tick();
    chk_zero("reset_outputs");
    rstn = 1'b1;

    // Single write with cycle-exact timing
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 8'hA5;
    tick();
    chk("wr_gnt0", 64'(gnt0), 64'd1);
    chk("wr_no_strobe_yet", 64'(ram_wr_en), 64'd0);
    tick();
    chk("wr_gnt0_pulse", 64'(gnt0), 64'd0);
    chk("wr_strobe", 64'({ram_wr_en, ram_rd_en}), 64'b10);
    chk("wr_addr", 64'(ram_addr), 64'd4);
    chk("wr_din", 64'(ram_din), 64'hA5);
    tick();
    chk("wr_strobe_one_cycle", 64'(ram_wr_en), 64'd0);

    // Single read with cycle-exact timing
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
    tick();
    chk("rd_gnt0", 64'(gnt0), 64'd1);
    tick();
    chk("rd_strobe", 64'({ram_wr_en, ram_rd_en}), 64'b01);
    chk("rd_addr", 64'(ram_addr), 64'd4);
    chk("rd_no_rvalid_yet", 64'(rvalid0), 64'd0);
    tick();
    chk("rd_rvalid0", 64'(rvalid0), 64'd1);
    chk("rd_rdata0", 64'(rdata0), 64'hA5);
    tick();
    chk("rd_rvalid0_pulse", 64'(rvalid0), 64'd0);
    chk("rd_rdata0_hold", 64'(rdata0), 64'hA5);
    chk("addr_hold_idle", 64'(ram_addr), 64'd4);

    // Contention from a fresh pointer
    do_reset();
    hold0 = 1'b1; hold1 = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2;  wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd15; wdata1 = 8'h22;
    ng = 0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      tick();
      if (gnt0) begin seq[ng] = 0; ng++; end
      else if (gnt1) begin seq[ng] = 1; ng++; end
    end
    hold0 = 1'b0; hold1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    chk("contention_grants", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk("contention_order", 64'(seq[k]), 64'd0);
`else
      chk("contention_order", 64'(seq[k]), 64'(k % 2));
`endif
    end
    tick();
    tick();
    run_cmd(1'b0, 1'b0, 4'd2, 8'h00);
    chk("readback_addr2", 64'(rdata0), 64'h11);
    run_cmd(1'b1, 1'b0, 4'd15, 8'h00);
`ifndef ARB_FIXED_PRIO_EN
    chk("readback_addr15", 64'(rdata1), 64'h22);
`endif

    // Back-to-back reads on requester 1 with req held
    run_cmd(1'b0, 1'b1, 4'd9, 8'h3C);
    run_cmd(1'b0, 1'b1, 4'd10, 8'hC3);
    hold1 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
    ng = 0; nr = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (gnt1 && ng < 2) begin
        gcyc[ng] = i; ng++;
        if (ng == 1) addr1 = 4'd10;
        else begin req1 = 1'b0; hold1 = 1'b0; end
      end
      if (rvalid1 && nr < 2) begin rcyc[nr] = i; nr++; end
    end
    hold1 = 1'b0; req1 = 1'b0;
    chk("b2b_gnt_count", 64'(ng), 64'd2);
    chk("b2b_rvalid_count", 64'(nr), 64'd2);
    if (ng == 2 && nr == 2) begin
      chk("b2b_gnt_spacing", 64'(gcyc[1] - gcyc[0]), 64'd3);
      chk("b2b_rvalid0_lat", 64'(rcyc[0] - gcyc[0]), 64'd2);
      chk("b2b_rvalid1_lat", 64'(rcyc[1] - gcyc[1]), 64'd2);
    end
    chk("b2b_last_rdata1", 64'(rdata1), 64'hC3);

    // Reset during the ACCESS cycle of a read
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd9;
    tick();
    chk("abort_gnt0", 64'(gnt0), 64'd1);
    rstn = 1'b0;
    tick();
    q0.delete();
    chk_zero("abort_outputs");
    tick();
    chk_zero("abort_outputs_held");
    rstn = 1'b1;
    tick();
    chk("abort_no_rvalid0", 64'(rvalid0), 64'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd9;
    tick();
    chk("abort_rr_ptr0", 64'({gnt0, gnt1}), 64'b10);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_req1_served", 64'(req1), 64'd0);

    // Random traffic on both requesters
    for (int i = 0; i < 200; i++) begin
      if (!req0 && $urandom_range(1, 0) == 1) begin
        req0 = 1'b1; we0 = 1'($urandom_range(1, 0));
        addr0 = 4'($urandom_range(15, 0)); wdata0 = 8'($urandom_range(255, 0));
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
        req1 = 1'b1; we1 = 1'($urandom_range(1, 0));
        addr1 = 4'($urandom_range(15, 0)); wdata1 = 8'($urandom_range(255, 0));
      end
      tick();
    end
    for (int i = 0; i < 12; i++) tick();
    chk("random_drain_req", 64'({req0, req1}), 64'd0);
    chk("random_q0_empty", 64'(q0.size()), 64'd0);
    chk("random_q1_empty", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
